astable_555: RTL and testbench

ASTABLE_555 -- requirements
Module: astable_555

---
 rtl/ic_555_pkg.sv | 17 +
 rtl/astable_555_if.sv | 10 +
 rtl/astable_555.sv | 79 +++++++
 tb/tb_astable_555.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ic_555_pkg.sv
// Shared types and helpers for the 555-style timer blocks (astable, oneshot).
package ic_555_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    FIRST = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  function automatic int count_max(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/astable_555_if.sv
// Oscillator control/observation bundle: run enable in, waveform and strobes out.
interface astable_555_if;
  logic EN;
  logic OUT;
  logic TRG_N;
  logic PERIOD_END;

  modport master (output EN, input OUT, input TRG_N, input PERIOD_END);
  modport slave  (input EN, output OUT, output TRG_N, output PERIOD_END);
endinterface

// File: rtl/astable_555.sv
// Clocked 555 astable model: FIRST charge from 0 V, then alternating HIGH/LOW phases.
module astable_555
  import ic_555_pkg::*;
#(
    parameter int HIGH_COUNTS  = 1000,
    parameter int LOW_COUNTS   = 1000,
    parameter int FIRST_COUNTS = 1500
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    output logic OUT,
    output logic TRG_N,
    output logic PERIOD_END
);

    localparam int CW = $clog2(count_max(HIGH_COUNTS, LOW_COUNTS, FIRST_COUNTS));
    localparam logic [CW-1:0] FIRST_END = CW'(FIRST_COUNTS - 1);
    localparam logic [CW-1:0] HIGH_END  = CW'(HIGH_COUNTS - 1);
    localparam logic [CW-1:0] LOW_END   = CW'(LOW_COUNTS - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_out, r_trg_n, r_pe;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (!EN) begin
            w_state_nxt = STOP;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                STOP: begin
                    w_state_nxt = FIRST;
                    w_cnt_nxt   = '0;
                end
                FIRST: if (r_cnt == FIRST_END) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end
                HIGH: if (r_cnt == HIGH_END) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end
                LOW: if (r_cnt == LOW_END) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    w_state_nxt = STOP;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= STOP;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_trg_n <= 1'b1;
            r_pe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= (w_state_nxt == FIRST) || (w_state_nxt == HIGH);
            r_trg_n <= !((w_state_nxt == LOW) && ((r_state == FIRST) || (r_state == HIGH)));
            r_pe    <= (w_state_nxt == LOW) && (w_cnt_nxt == LOW_END);
        end
    end

    assign OUT        = r_out;
    assign TRG_N      = r_trg_n;
    assign PERIOD_END = r_pe;

endmodule

// File: tb/tb_astable_555.sv
// Self-checking bench for astable_555: vector table, corner sequences, random EN/RESET vs model.
module tb_astable_555;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    astable_555_if ifa ();
    astable_555_if ifb ();
    assign ifb.EN = ifa.EN;

    astable_555 #(.HIGH_COUNTS(4), .LOW_COUNTS(3), .FIRST_COUNTS(6)) u_dut_a (
        .CLK(clk), .RESET(rst), .EN(ifa.EN),
        .OUT(ifa.OUT), .TRG_N(ifa.TRG_N), .PERIOD_END(ifa.PERIOD_END));

    astable_555 #(.HIGH_COUNTS(2), .LOW_COUNTS(2), .FIRST_COUNTS(2)) u_dut_b (
        .CLK(clk), .RESET(rst), .EN(ifb.EN),
        .OUT(ifb.OUT), .TRG_N(ifb.TRG_N), .PERIOD_END(ifb.PERIOD_END));

    int errors = 0;
    int checks = 0;
    bit auto_chk = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: k = cycles since the run started (-1 when stopped); {OUT,TRG_N,PERIOD_END}.
    function automatic logic [2:0] ref3(input int k, input int f, input int h, input int l);
        int m;
        if (k < 0) return 3'b010;
        if (k < f) return 3'b110;
        m = (k - f) % (h + l);
        if (m < l) return {1'b0, (m != 0), (m == l - 1)};
        return 3'b110;
    endfunction

    int ka = -1, kb = -1;
    always @(posedge clk or posedge rst) begin
        if (rst || !ifa.EN) begin
            ka <= -1;
            kb <= -1;
        end else begin
            ka <= ka + 1;
            kb <= kb + 1;
        end
    end

    always @(negedge clk) begin
        if (auto_chk) begin
            check("model_a", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), int'(ref3(ka, 6, 4, 3)));
            check("model_b", int'({ifb.OUT, ifb.TRG_N, ifb.PERIOD_END}), int'(ref3(kb, 2, 2, 2)));
        end
    end

    typedef struct {
        logic en;
        logic out;
        logic trg_n;
        logic pe;
    } vec_t;
    vec_t vec[17];

    initial begin
        logic [0:16] p_out, p_trg, p_pe;
        int pe_cnt, last_pe, bad_gap, hi_run;
        bit found, run_on;

        p_out = 17'b111111_000_1111_000_1;
        p_trg = 17'b111111_011_1111_011_1;
        p_pe  = 17'b000000_001_0000_001_0;
        for (int i = 0; i < 17; i++) begin
            vec[i].en    = 1'b1;
            vec[i].out   = p_out[i];
            vec[i].trg_n = p_trg[i];
            vec[i].pe    = p_pe[i];
        end

        rst = 1'b1;
        ifa.EN = 1'b0;
        #1;
        check("reset_state", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b010);
        auto_chk = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Waveform table after reset release
        for (int i = 0; i < 17; i++) begin
            ifa.EN = vec[i].en;
            @(negedge clk);
            check($sformatf("vec%0d", i + 1), int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}),
                  int'({vec[i].out, vec[i].trg_n, vec[i].pe}));
        end

        // PERIOD_END strobe count and spacing over cycles 10..79
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pe_cnt = 0; last_pe = 0; bad_gap = 0;
        for (int c = 1; c <= 79; c++) begin
            @(negedge clk);
            if (c >= 10 && ifa.PERIOD_END) begin
                if (last_pe != 0 && c - last_pe != 7) bad_gap++;
                last_pe = c;
                pe_cnt++;
            end
        end
        check("pe_count", pe_cnt, 10);
        check("pe_spacing", bad_gap, 0);

        // EN dropped in second LOW cycle
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (!ifa.TRG_N) found = 1'b1;
        end
        check("wait_trg", int'(found), 1);
        @(negedge clk);
        ifa.EN = 1'b0;
        @(negedge clk);
        check("en_drop", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b010);
        ifa.EN = 1'b1;
        hi_run = 0; run_on = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (run_on && ifa.OUT) hi_run++;
            else run_on = 1'b0;
        end
        check("restart_first_len", hi_run, 6);

        // Async reset between edges during HIGH
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (ifa.PERIOD_END) found = 1'b1;
        end
        check("wait_pe", int'(found), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b010);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hold", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b010);
        @(negedge clk);
        check("rst_restart", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b110);

        // One-cycle EN pulse from STOP
        ifa.EN = 1'b0;
        repeat (3) @(negedge clk);
        ifa.EN = 1'b1;
        @(negedge clk);
        check("pulse_first", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b110);
        ifa.EN = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("pulse_stop", int'({ifa.OUT, ifa.TRG_N, ifa.PERIOD_END}), 3'b010);
        end

        // Random EN with occasional mid-cycle reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ifa.EN = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        auto_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
